pipe_rc_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor that replaces the fixed 4-bit combinational full-bit ripple adder in arithmetic datapaths. Operands of WIDTH bits are split into CHUNK-bit slices, with one slice resolved per pipeline stage and the carry registered between stages. This gives one result per cycle at any width, with a valid/ready handshake on both sides. It adds signed overflow detection and a subtract mode.

---
 rtl/pipe_rc_adder.sv | 114 +++++++++++
 tb/tb_pipe_rc_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rc_adder.sv
// rtl/pipe_rc_adder.sv - pipelined ripple-carry adder/subtractor, one CHUNK slice per stage
//
// Purpose:
//   Adds (or subtracts) two WIDTH-bit operands, resolving CHUNK bits per
//   pipeline stage with the carry registered between stages. One result
//   per cycle, valid/ready handshake on both sides, global stall enable.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present
//   in_ready   operand set accepted this cycle when in_valid is high
//   A, B       operands (WIDTH bits)
//   C          carry-in, used only when Sub = 0
//   Sub        0: A + B + C, 1: A - B
//   out_valid  result present
//   out_ready  downstream accepts the result
//   S          sum or difference (modulo 2^WIDTH)
//   Carry      carry out of the MSB (subtract: 1 = no borrow)
//   Ovf        two's-complement signed overflow

module pipe_rc_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Carry,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Register level 0 is the operand capture; level k+1 holds the result of
  // stage k. Operands are only needed up to the last stage's input.
  logic             vld     [0:STAGES];
  logic             cy      [0:STAGES];
  logic [WIDTH-1:0] psum    [0:STAGES];
  logic [WIDTH-1:0] op_a    [0:LAST];
  logic [WIDTH-1:0] op_b    [0:LAST];
  logic             ovf_q;

  logic [CHUNK:0]   slice_sum [0:LAST];
  logic [WIDTH-1:0] psum_next [0:LAST];
  logic             ovf_next;
  logic             en;

  // A single enable freezes the whole pipe whenever the output is blocked.
  assign en       = !vld[STAGES] || out_ready;
  assign in_ready = en;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, op_a[k][k*CHUNK +: CHUNK]}
                   + {1'b0, op_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cy[k]};
      // Lower slices already resolved ride along (skew registers).
      psum_next[k] = psum[k];
      psum_next[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
    end
    // Carry into the MSB equals a ^ b ^ s at that bit, so overflow is
    // carry_out ^ a_msb ^ b_msb ^ s_msb; B is already inverted for Sub.
    ovf_next = slice_sum[LAST][CHUNK] ^ op_a[LAST][WIDTH-1]
             ^ op_b[LAST][WIDTH-1] ^ slice_sum[LAST][CHUNK-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        vld[k]  <= 1'b0;
        cy[k]   <= 1'b0;
        psum[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      // Subtract is folded in at capture: A + ~B + 1, C ignored.
      vld[0]  <= in_valid;
      op_a[0] <= A;
      op_b[0] <= Sub ? ~B : B;
      cy[0]   <= Sub | C;
      psum[0] <= '0;
      for (int k = 0; k < STAGES; k++) begin
        vld[k+1]  <= vld[k];
        cy[k+1]   <= slice_sum[k][CHUNK];
        psum[k+1] <= psum_next[k];
      end
      for (int k = 0; k < LAST; k++) begin
        op_a[k+1] <= op_a[k];
        op_b[k+1] <= op_b[k];
      end
      ovf_q <= ovf_next;
    end
  end

  assign out_valid = vld[STAGES];
  assign S         = psum[STAGES];
  assign Carry     = cy[STAGES];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_rc_adder.sv
// tb/tb_pipe_rc_adder.sv - self-checking bench for pipe_rc_adder (WIDTH=16, CHUNK=4)

module tb_pipe_rc_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        C = 1'b0;
  logic        Sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] S;
  logic        Carry;
  logic        Ovf;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          popped = 0;
  int          issued = 0;
  int          lat = 0;
  logic [17:0] exp_q [$];
  logic [17:0] next_exp = '0;
  logic [17:0] prev_out = '0;
  logic        prev_stall = 1'b0;
  logic        last_in_xfer = 1'b0;
  logic        need_new = 1'b1;

  always #5 clk = ~clk;

  pipe_rc_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .Sub(Sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .Carry(Carry), .Ovf(Ovf)
  );

  // Reference: plain integer arithmetic; result packed as {S, Carry, Ovf}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic sub);
    int ua, ub, sa, sb, r, sr;
    logic carry, ovf;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (sub) begin
      r = ua - ub; carry = (ua >= ub); sr = sa - sb;
    end else begin
      r = ua + ub + c; carry = (r > 65535); sr = sa + sb + c;
    end
    ovf = (sr > 32767) || (sr < -32768);
    return {r[15:0], carry, ovf};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // One clock cycle: observe at negedge, score transfers, advance past posedge.
  task automatic step();
    logic [17:0] e;
    @(negedge clk);
    if (prev_stall)
      check("stall_hold", {13'd0, out_valid, S, Carry, Ovf}, {13'd0, 1'b1, prev_out});
    check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        popped++;
        check("result", {14'd0, S, Carry, Ovf}, {14'd0, e});
      end
    end
    last_in_xfer = in_valid && in_ready;
    if (last_in_xfer) exp_q.push_back(next_exp);
    prev_stall = out_valid && !out_ready;
    prev_out   = {S, Carry, Ovf};
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic sub, input logic [17:0] e);
    int n;
    A = a; B = b; C = c; Sub = sub;
    next_exp = e;
    in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_in_xfer && n < 20);
    if (!last_in_xfer) check("issue_timeout", {31'd0, last_in_xfer}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held with random inputs
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = 16'($urandom_range(0, 65535));
      B = 16'($urandom_range(0, 65535));
      C = 1'($urandom_range(0, 1));
      Sub = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_outputs", {14'd0, out_valid, S, Carry}, 32'd0);
      check("reset_ovf", {31'd0, Ovf}, 32'd0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Basic add with latency measurement
    A = 16'h0000; B = 16'h0005; C = 1'b0; Sub = 1'b0;
    next_exp = {16'h0005, 1'b0, 1'b0};
    in_valid = 1'b1;
    step();
    check("first_accept", {31'd0, last_in_xfer}, 32'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check("latency", lat, 32'd4);
    drain();

    // Directed carry, overflow and subtract cases, back to back
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b1});
    issue(16'h00FF, 16'h0000, 1'b1, 1'b0, {16'h0100, 1'b0, 1'b0});
    issue(16'h0003, 16'h0005, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
    in_valid = 1'b0;
    drain();

    // Random back-to-back operations under pseudo-random backpressure
    popped = 0;
    issued = 0;
    need_new = 1'b1;
    for (int cyc = 0; cyc < 300 && (issued < 8 || exp_q.size() > 0); cyc++) begin
      if (issued < 8) begin
        in_valid = 1'b1;
        if (need_new) begin
          A = 16'($urandom_range(0, 65535));
          B = 16'($urandom_range(0, 65535));
          C = 1'($urandom_range(0, 1));
          Sub = 1'($urandom_range(0, 1));
          next_exp = model(A, B, C, Sub);
          need_new = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_in_xfer) begin
        issued++;
        need_new = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_issued", issued, 32'd8);
    check("rand_results", popped, 32'd8);
    check("rand_drained", exp_q.size(), 32'd0);

    // Reset in the middle of traffic
    for (int i = 0; i < 4; i++) begin
      A = 16'($urandom_range(0, 65535));
      B = 16'($urandom_range(0, 65535));
      C = 1'($urandom_range(0, 1));
      Sub = 1'($urandom_range(0, 1));
      issue(A, B, C, Sub, model(A, B, C, Sub));
    end
    in_valid = 1'b0;
    step();
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {13'd0, out_valid, S, Carry, Ovf}, 32'd0);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
